// File: rtl/transpose_writeback.sv
// Column-in / row-out tile transposer with a double-buffered tile store.
// Columns fill the write half while the read half streams rows to memory.
module transpose_writeback #(
    parameter int FETCH_WIDTH = 4,
    parameter int PIXEL_WIDTH = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [FETCH_WIDTH*PIXEL_WIDTH-1:0] col_pixels,
    input  logic                               col_valid,
    output logic                               col_ready,
    input  logic                               flush,
    output logic [FETCH_WIDTH*PIXEL_WIDTH-1:0] mem_data,
    output logic [FETCH_WIDTH-1:0]             mem_valid_mask,
    output logic                               mem_valid,
    input  logic                               mem_ready
);

    localparam int IW = $clog2(FETCH_WIDTH);
    localparam int CW = IW + 1;

    // Handshakes: a column transfers on the rising edge where col_valid && col_ready;
    // a row transfers where mem_valid && mem_ready, and mem_* hold steady while stalled.

    logic [PIXEL_WIDTH-1:0] tile [2][FETCH_WIDTH][FETCH_WIDTH];

    logic [IW-1:0] col_index;
    logic [IW-1:0] row_index;
    logic          switch_flag;
    logic          pending;
    logic          read_full;
    logic [CW-1:0] pend_count;
    logic [CW-1:0] read_count;

    logic          accept;
    logic          last_col;
    logic          close_col;
    logic          close_idle;
    logic          close_now;
    logic [CW-1:0] close_count;
    logic          row_hs;
    logic          read_done;
    logic          read_free;
    logic          swap;

    assign col_ready = !pending;
    assign mem_valid = read_full;

    always_comb begin
        accept      = col_valid && col_ready;
        last_col    = (col_index == IW'(FETCH_WIDTH - 1));
        close_col   = accept && (last_col || flush);
        // An idle flush only matters when a partial tile is actually open.
        close_idle  = !col_valid && flush && (col_index != '0) && !pending;
        close_now   = close_col || close_idle;
        close_count = close_col ? ({1'b0, col_index} + CW'(1)) : {1'b0, col_index};
        row_hs      = read_full && mem_ready;
        read_done   = row_hs && (row_index == IW'(FETCH_WIDTH - 1));
        read_free   = !read_full || read_done;
        swap        = (pending || close_now) && read_free;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_index   <= '0;
            row_index   <= '0;
            switch_flag <= 1'b0;
            pending     <= 1'b0;
            read_full   <= 1'b0;
            pend_count  <= '0;
            read_count  <= '0;
        end else begin
            if (close_now) begin
                col_index <= '0;
            end else if (accept) begin
                col_index <= col_index + IW'(1);
            end

            if (swap) begin
                switch_flag <= ~switch_flag;
                read_full   <= 1'b1;
                read_count  <= pending ? pend_count : close_count;
                row_index   <= '0;
                pending     <= 1'b0;
            end else begin
                if (close_now) begin
                    pending    <= 1'b1;
                    pend_count <= close_count;
                end
                if (read_done) begin
                    read_full <= 1'b0;
                    row_index <= '0;
                end else if (row_hs) begin
                    row_index <= row_index + IW'(1);
                end
            end
        end
    end

    // Pixel storage carries no reset; occupancy flags alone decide what is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                tile[switch_flag][i][col_index] <= col_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

    always_comb begin
        mem_data       = '0;
        mem_valid_mask = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (read_full && (CW'(j) < read_count)) begin
                mem_valid_mask[j]                      = 1'b1;
                mem_data[j*PIXEL_WIDTH +: PIXEL_WIDTH] = tile[~switch_flag][row_index][j];
            end
        end
    end

endmodule

// File: tb/tb_transpose_writeback.sv
// Bench for transpose_writeback (FETCH_WIDTH=4, PIXEL_WIDTH=4): table vectors,
// hand-written corner sequences and a row scoreboard fed by a transpose model.
module tb_transpose_writeback;

    localparam int F  = 4;
    localparam int P  = 4;
    localparam int LW = F * P;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] col_pixels = '0;
    logic          col_valid = 1'b0;
    logic          col_ready;
    logic          flush = 1'b0;
    logic [LW-1:0] mem_data;
    logic [F-1:0]  mem_valid_mask;
    logic          mem_valid;
    logic          mem_ready = 1'b0;

    transpose_writeback #(.FETCH_WIDTH(F), .PIXEL_WIDTH(P)) dut (
        .clk            (clk),
        .rst            (rst),
        .col_pixels     (col_pixels),
        .col_valid      (col_valid),
        .col_ready      (col_ready),
        .flush          (flush),
        .mem_data       (mem_data),
        .mem_valid_mask (mem_valid_mask),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready)
    );

    always #5 clk = ~clk;

    int vec_count  = 0;
    int miss_count = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected rows as {mask, data}.
    logic [F+LW-1:0] exp_q[$];

    // Transpose model of the tile being filled.
    logic [LW-1:0] m_cols [F];
    int            m_cnt = 0;

    typedef struct {
        logic [LW-1:0] col;
        logic [LW-1:0] row;
    } vec_t;
    vec_t tbl [F];

    // Streaming window bookkeeping.
    bit win_on    = 0;
    int win_first = -1;
    int win_last  = -1;
    int win_rows  = 0;
    int win_drop  = 0;

    bit            stall_prev = 0;
    logic [LW-1:0] prev_data;
    logic [F-1:0]  prev_mask;
    bit            rand_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_close();
        logic [LW-1:0] row;
        logic [F-1:0]  mask;
        if (m_cnt == 0) return;
        mask = '0;
        for (int j = 0; j < m_cnt; j++) mask[j] = 1'b1;
        for (int r = 0; r < F; r++) begin
            row = '0;
            for (int j = 0; j < m_cnt; j++) row[j*P +: P] = m_cols[j][r*P +: P];
            exp_q.push_back({mask, row});
        end
        m_cnt = 0;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_col(input logic [LW-1:0] col, input logic fl, input bit use_model);
        int guard = 0;
        while (!col_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!col_ready) begin
            check("col_ready_timeout", 32'(col_ready), 32'd1);
            return;
        end
        col_pixels = col;
        col_valid  = 1'b1;
        flush      = fl;
        if (use_model) begin
            m_cols[m_cnt] = col;
            m_cnt++;
            if (m_cnt == F || fl) model_close();
        end
        @(posedge clk); #1;
        col_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic flush_idle();
        col_valid = 1'b0;
        flush     = 1'b1;
        model_close();
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        mem_ready = 1'b1;
        while ((exp_q.size() != 0 || mem_valid) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_rows_left", 32'(exp_q.size()), 32'd0);
        check("drain_mem_valid", 32'(mem_valid), 32'd0);
    endtask

    // Row monitor: pops the scoreboard and checks stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("stall_data", 32'(mem_data), 32'(prev_data));
                check("stall_mask", 32'(mem_valid_mask), 32'(prev_mask));
                check("stall_valid", 32'(mem_valid), 32'd1);
            end
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_row", 32'(mem_data), 32'hDEAD);
                end else begin
                    logic [F+LW-1:0] e;
                    e = exp_q.pop_front();
                    check("row_data", 32'(mem_data), 32'(e[LW-1:0]));
                    check("row_mask", 32'(mem_valid_mask), 32'(e[F+LW-1:LW]));
                end
                if (win_on) begin
                    if (win_first < 0) win_first = cyc;
                    win_last = cyc;
                    win_rows++;
                end
            end
            if (win_on && !col_ready) win_drop++;
            stall_prev = mem_valid && !mem_ready;
            prev_data  = mem_data;
            prev_mask  = mem_valid_mask;
        end
    end

    initial begin
        tbl[0] = '{col: 16'h3210, row: 16'hC840};
        tbl[1] = '{col: 16'h7654, row: 16'hD951};
        tbl[2] = '{col: 16'hBA98, row: 16'hEA62};
        tbl[3] = '{col: 16'hFEDC, row: 16'hFB73};

        // Reset state
        #1;
        check("rst_col_ready", 32'(col_ready), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mask", 32'(mem_valid_mask), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Table-driven full tile, back-to-back columns
        mem_ready = 1'b1;
        for (int k = 0; k < F; k++) exp_q.push_back({4'hF, tbl[k].row});
        for (int k = 0; k < F; k++) begin
            send_col(tbl[k].col, 1'b0, 1'b0);
            col_valid = (k < F - 1);
            if (k < F - 1) col_pixels = tbl[k+1].col;
            check("latency_mem_valid", 32'(mem_valid), (k == F - 1) ? 32'd1 : 32'd0);
        end
        check("first_mask", 32'(mem_valid_mask), 32'hF);
        check("first_row", 32'(mem_data), 32'hC840);
        drain();

        // Two tiles streamed continuously
        win_on = 1;
        for (int k = 0; k < 2 * F; k++) send_col(LW'($urandom), 1'b0, 1'b1);
        drain();
        win_on = 0;
        check("stream_rows", 32'(win_rows), 32'd8);
        check("stream_span", 32'(win_last - win_first), 32'd7);
        check("stream_ready_drop", 32'(win_drop), 32'd0);

        // Backpressure: second tile goes pending until the last tile-1 row leaves
        mem_ready = 1'b0;
        for (int k = 0; k < 2 * F; k++) send_col(LW'($urandom), 1'b0, 1'b1);
        check("pend_col_ready", 32'(col_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("pend_hold", 32'(col_ready), 32'd0);
        mem_ready = 1'b1;
        for (int k = 0; k < F; k++) begin
            check("pend_before_last", 32'(col_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("pend_release", 32'(col_ready), 32'd1);
        drain();

        // Flush on an empty write half is ignored
        flush_idle();
        repeat (2) @(posedge clk);
        #1;
        check("empty_flush", 32'(mem_valid), 32'd0);

        // Partial tile closed by an idle flush
        mem_ready = 1'b0;
        send_col(16'h0011, 1'b0, 1'b1);
        send_col(16'h0022, 1'b0, 1'b1);
        flush_idle();
        check("partial_valid", 32'(mem_valid), 32'd1);
        check("partial_mask", 32'(mem_valid_mask), 32'h3);
        check("partial_row0", 32'(mem_data), 32'h0021);
        drain();

        // Partial tile closed by flush riding on a column
        send_col(16'h1234, 1'b0, 1'b1);
        send_col(16'h5678, 1'b0, 1'b1);
        send_col(16'h9ABC, 1'b1, 1'b1);
        check("colflush_mask", 32'(mem_valid_mask), 32'h7);
        drain();

        // Asynchronous reset in mid-operation
        mem_ready = 1'b0;
        for (int k = 0; k < F + 2; k++) send_col(LW'($urandom), 1'b0, 1'b1);
        check("pre_rst_valid", 32'(mem_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_mem_valid", 32'(mem_valid), 32'd0);
        check("async_col_ready", 32'(col_ready), 32'd1);
        check("async_mask", 32'(mem_valid_mask), 32'd0);
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < F; k++) send_col(LW'($urandom), 1'b0, 1'b1);
        drain();

        // Random backpressure and random flushes against the scoreboard
        fork
            begin
                for (int k = 0; k < 40; k++) send_col(LW'($urandom), ($urandom_range(0, 5) == 0), 1'b1);
                if (m_cnt > 0) flush_idle();
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    mem_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
